// File: rtl/ctrl_pkg.sv
// Shared control-bundle type and encodings for the ID->EX->MEM->WB control pipeline.
package ctrl_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       Branch;
    logic       jump;
  } ctrl_t;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  localparam logic [1:0] ALUOP_ADD = 2'd0;
  localparam logic [1:0] ALUOP_SUB = 2'd1;
  localparam logic [1:0] ALUOP_R   = 2'd2;
  localparam logic [1:0] ALUOP_I   = 2'd3;

  // All-zero bundle: no register write, no memory access.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One control pipeline register (bundle + destination register) with hold and bubble-clear.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             clear,
  input  ctrl_t            ctrl_d,
  input  logic [REG_W-1:0] rd_d,
  output ctrl_t            ctrl_q,
  output logic [REG_W-1:0] rd_q
);

  // Hold outranks clear so a frozen pipeline never loses an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
      rd_q   <= '0;
    end else if (!hold) begin
      if (clear) begin
        ctrl_q <= CTRL_NOP;
        rd_q   <= '0;
      end else begin
        ctrl_q <= ctrl_d;
        rd_q   <= rd_d;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID->EX->MEM->WB with load-use stall, flush, global hold and bubble counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic [1:0]       MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             Branch_i,
  input  logic             jump_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic [1:0]       ex_ALUOp_o,
  output logic             ex_ALUSrc_o,
  output logic             ex_Branch_o,
  output logic             ex_jump_o,
  output logic             ex_MemRead_o,
  output logic [REG_W-1:0] ex_rd_o,
  output logic             mem_MemRead_o,
  output logic             mem_MemWrite_o,
  output logic             mem_RegWrite_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic             wb_RegWrite_o,
  output logic [1:0]       wb_MemtoReg_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_t            id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             hz, stall, bubble;
  logic [CNT_W-1:0] bubble_cnt;

  assign id_ctrl = '{RegWrite: RegWrite_i, MemtoReg: MemtoReg_i, MemRead: MemRead_i,
                     MemWrite: MemWrite_i, ALUOp: ALUOp_i, ALUSrc: ALUSrc_i,
                     Branch: Branch_i, jump: jump_i};

  // Load-use hazard against the instruction currently in EX; x0 never hazards.
  assign hz     = ex_ctrl.MemRead && (ex_rd != '0) && ((ex_rd == rs1_i) || (ex_rd == rs2_i));
  assign stall  = hz && !flush_i && !hold_i;
  assign bubble = !hold_i && (flush_i || stall);

  // ID/EX
  ctrl_stage_reg #(.REG_W(REG_W)) u_id_ex (
    .clk(clk_i), .rst_n(rst_i), .hold(hold_i), .clear(flush_i || stall),
    .ctrl_d(id_ctrl), .rd_d(rd_i), .ctrl_q(ex_ctrl), .rd_q(ex_rd)
  );

  // EX/MEM
  ctrl_stage_reg #(.REG_W(REG_W)) u_ex_mem (
    .clk(clk_i), .rst_n(rst_i), .hold(hold_i), .clear(1'b0),
    .ctrl_d(ex_ctrl), .rd_d(ex_rd), .ctrl_q(mem_ctrl), .rd_q(mem_rd)
  );

  // MEM/WB
  ctrl_stage_reg #(.REG_W(REG_W)) u_mem_wb (
    .clk(clk_i), .rst_n(rst_i), .hold(hold_i), .clear(1'b0),
    .ctrl_d(mem_ctrl), .rd_d(mem_rd), .ctrl_q(wb_ctrl), .rd_q(wb_rd)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt <= '0;
    end else if (bubble) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  // WB only consumes RegWrite/MemtoReg; the rest of the bundle retires here.
  logic unused_wb;
  assign unused_wb = ^{wb_ctrl.MemRead, wb_ctrl.MemWrite, wb_ctrl.ALUOp,
                       wb_ctrl.ALUSrc, wb_ctrl.Branch, wb_ctrl.jump};

  assign stall_o        = stall;
  assign ex_ALUOp_o     = ex_ctrl.ALUOp;
  assign ex_ALUSrc_o    = ex_ctrl.ALUSrc;
  assign ex_Branch_o    = ex_ctrl.Branch;
  assign ex_jump_o      = ex_ctrl.jump;
  assign ex_MemRead_o   = ex_ctrl.MemRead;
  assign ex_rd_o        = ex_rd;
  assign mem_MemRead_o  = mem_ctrl.MemRead;
  assign mem_MemWrite_o = mem_ctrl.MemWrite;
  assign mem_RegWrite_o = mem_ctrl.RegWrite;
  assign mem_rd_o       = mem_rd;
  assign wb_RegWrite_o  = wb_ctrl.RegWrite;
  assign wb_MemtoReg_o  = wb_ctrl.MemtoReg;
  assign wb_rd_o        = wb_rd;
  assign bubble_cnt_o   = bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed, table-driven bench for ctrl_pipe (counter narrowed to 4 bits to reach saturation).
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  ctrl_t            id;
  logic [REG_W-1:0] rs1, rs2, rd;
  logic             flush, hold;
  logic             stall_o, ex_ALUSrc_o, ex_Branch_o, ex_jump_o, ex_MemRead_o;
  logic [1:0]       ex_ALUOp_o, wb_MemtoReg_o;
  logic [REG_W-1:0] ex_rd_o, mem_rd_o, wb_rd_o;
  logic             mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o, wb_RegWrite_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(id.RegWrite), .MemtoReg_i(id.MemtoReg), .MemRead_i(id.MemRead),
    .MemWrite_i(id.MemWrite), .ALUOp_i(id.ALUOp), .ALUSrc_i(id.ALUSrc),
    .Branch_i(id.Branch), .jump_i(id.jump),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush), .hold_i(hold),
    .stall_o(stall_o),
    .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_Branch_o(ex_Branch_o),
    .ex_jump_o(ex_jump_o), .ex_MemRead_o(ex_MemRead_o), .ex_rd_o(ex_rd_o),
    .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o),
    .mem_RegWrite_o(mem_RegWrite_o), .mem_rd_o(mem_rd_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_MemtoReg_o(wb_MemtoReg_o), .wb_rd_o(wb_rd_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  typedef struct {
    ctrl_t      c;
    logic [4:0] rs1, rs2, rd;
    logic       flush;
    logic       e_stall;
    logic [1:0] e_alu;
    logic [4:0] e_exrd;
    logic       e_exmr;
    logic       e_mrw;
    logic [4:0] e_mrd;
    logic       e_wrw;
    logic [4:0] e_wrd;
    logic [1:0] e_wmtr;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ctrl_t mk(input logic rw, input logic [1:0] mtr, input logic mr,
                               input logic mw, input logic [1:0] alu, input logic src);
    ctrl_t c;
    c = '{RegWrite: rw, MemtoReg: mtr, MemRead: mr, MemWrite: mw,
          ALUOp: alu, ALUSrc: src, Branch: 1'b0, jump: 1'b0};
    return c;
  endfunction

  function automatic vec_t v(input ctrl_t c, input int r1, input int r2, input int d,
                             input logic fl, input logic st, input int alu, input int exrd,
                             input logic exmr, input logic mrw, input int mrd,
                             input logic wrw, input int wrd, input int wmtr, input int cnt);
    vec_t t;
    t.c = c; t.rs1 = 5'(r1); t.rs2 = 5'(r2); t.rd = 5'(d); t.flush = fl;
    t.e_stall = st; t.e_alu = 2'(alu); t.e_exrd = 5'(exrd); t.e_exmr = exmr;
    t.e_mrw = mrw; t.e_mrd = 5'(mrd); t.e_wrw = wrw; t.e_wrd = 5'(wrd);
    t.e_wmtr = 2'(wmtr); t.e_cnt = 4'(cnt);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ctrl_t c, input int r1, input int r2, input int d);
    id = c; rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, 32'(stall_o), 0);
    chk({tag, " ex_ALUOp"}, 32'(ex_ALUOp_o), 0);
    chk({tag, " ex_misc"}, 32'({ex_ALUSrc_o, ex_Branch_o, ex_jump_o, ex_MemRead_o}), 0);
    chk({tag, " ex_rd"}, 32'(ex_rd_o), 0);
    chk({tag, " mem_ctl"}, 32'({mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o}), 0);
    chk({tag, " mem_rd"}, 32'(mem_rd_o), 0);
    chk({tag, " wb_ctl"}, 32'({wb_RegWrite_o, wb_MemtoReg_o}), 0);
    chk({tag, " wb_rd"}, 32'(wb_rd_o), 0);
    chk({tag, " cnt"}, 32'(bubble_cnt_o), 0);
  endtask

  initial begin
    ctrl_t nop, rty, ld, ld0, ity, st;
    nop = CTRL_NOP;
    rty = mk(1'b1, MTR_ALU, 1'b0, 1'b0, ALUOP_R, 1'b0);
    ld  = mk(1'b1, MTR_MEM, 1'b1, 1'b0, ALUOP_ADD, 1'b1);
    ld0 = ld;
    ity = mk(1'b1, MTR_ALU, 1'b0, 1'b0, ALUOP_I, 1'b1);
    st  = mk(1'b0, MTR_ALU, 1'b0, 1'b1, ALUOP_ADD, 1'b1);

    //            c    rs1 rs2 rd  fl  st  alu exrd exmr mrw mrd wrw wrd wmtr cnt
    vecs[0]  = v(rty,  1,  2,  5, 0,  0,  2,  5,  0,  0,  0,  0,  0,  0,  0);
    vecs[1]  = v(nop,  0,  0,  0, 0,  0,  0,  0,  0,  1,  5,  0,  0,  0,  0);
    vecs[2]  = v(nop,  0,  0,  0, 0,  0,  0,  0,  0,  0,  0,  1,  5,  0,  0);
    vecs[3]  = v(ld,   2,  0,  7, 0,  0,  0,  7,  1,  0,  0,  0,  0,  0,  0);
    vecs[4]  = v(rty,  7,  3,  9, 0,  1,  0,  0,  0,  1,  7,  0,  0,  0,  1);
    vecs[5]  = v(rty,  7,  3,  9, 0,  0,  2,  9,  0,  0,  0,  1,  7,  1,  1);
    vecs[6]  = v(ld0,  4,  0,  0, 0,  0,  0,  0,  1,  1,  9,  0,  0,  0,  1);
    vecs[7]  = v(ity,  0,  0, 10, 0,  0,  3, 10,  0,  1,  0,  1,  9,  0,  1);
    vecs[8]  = v(ld,   1,  0,  7, 0,  0,  0,  7,  1,  1, 10,  1,  0,  1,  1);
    vecs[9]  = v(rty,  8,  9, 11, 0,  0,  2, 11,  0,  1,  7,  1, 10,  0,  1);
    vecs[10] = v(ld,   0,  0,  3, 0,  0,  0,  3,  1,  1, 11,  1,  7,  1,  1);
    vecs[11] = v(rty,  5,  3, 12, 1,  0,  0,  0,  0,  1,  3,  1, 11,  0,  2);
    vecs[12] = v(nop,  0,  0,  0, 0,  0,  0,  0,  0,  0,  0,  1,  3,  1,  2);

    drive(nop, 0, 0, 0);
    flush = 1'b0; hold = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].c, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      flush = vecs[i].flush;
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
      step();
      chk($sformatf("v%0d ex_ALUOp", i), 32'(ex_ALUOp_o), 32'(vecs[i].e_alu));
      chk($sformatf("v%0d ex_rd", i), 32'(ex_rd_o), 32'(vecs[i].e_exrd));
      chk($sformatf("v%0d ex_MemRead", i), 32'(ex_MemRead_o), 32'(vecs[i].e_exmr));
      chk($sformatf("v%0d mem_RegWrite", i), 32'(mem_RegWrite_o), 32'(vecs[i].e_mrw));
      chk($sformatf("v%0d mem_rd", i), 32'(mem_rd_o), 32'(vecs[i].e_mrd));
      chk($sformatf("v%0d wb_RegWrite", i), 32'(wb_RegWrite_o), 32'(vecs[i].e_wrw));
      chk($sformatf("v%0d wb_rd", i), 32'(wb_rd_o), 32'(vecs[i].e_wrd));
      chk($sformatf("v%0d wb_MemtoReg", i), 32'(wb_MemtoReg_o), 32'(vecs[i].e_wmtr));
      chk($sformatf("v%0d cnt", i), 32'(bubble_cnt_o), 32'(vecs[i].e_cnt));
    end
    flush = 1'b0;

    // Hold with a load in EX (hazard pending) and a store in MEM.
    drive(st, 1, 2, 0);
    step();
    drive(ld, 0, 0, 4);
    step();
    drive(rty, 4, 0, 13);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d stall", k), 32'(stall_o), 0);
      step();
      chk($sformatf("hold%0d ex_MemRead", k), 32'(ex_MemRead_o), 1);
      chk($sformatf("hold%0d ex_rd", k), 32'(ex_rd_o), 4);
      chk($sformatf("hold%0d ex_ALUSrc", k), 32'(ex_ALUSrc_o), 1);
      chk($sformatf("hold%0d mem_MemWrite", k), 32'(mem_MemWrite_o), 1);
      chk($sformatf("hold%0d mem_RegWrite", k), 32'(mem_RegWrite_o), 0);
      chk($sformatf("hold%0d wb_RegWrite", k), 32'(wb_RegWrite_o), 0);
      chk($sformatf("hold%0d wb_rd", k), 32'(wb_rd_o), 0);
      chk($sformatf("hold%0d cnt", k), 32'(bubble_cnt_o), 2);
    end
    hold = 1'b0;
    #1;
    chk("unhold stall", 32'(stall_o), 1);
    step();
    chk("unhold ex_rd", 32'(ex_rd_o), 0);
    chk("unhold mem_MemRead", 32'(mem_MemRead_o), 1);
    chk("unhold mem_rd", 32'(mem_rd_o), 4);
    chk("unhold wb_MemWrite_path", 32'(wb_RegWrite_o), 0);
    chk("unhold cnt", 32'(bubble_cnt_o), 3);

    // Asynchronous reset while a stall is being raised.
    drive(ld, 0, 0, 6);
    step();
    drive(rty, 6, 0, 14);
    #1;
    chk("prerst stall", 32'(stall_o), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    drive(nop, 0, 0, 0);

    // Saturation of the 4-bit bubble counter via 20 consecutive flushes.
    flush = 1'b1;
    drive(rty, 1, 2, 3);
    step();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sat%0d cnt", k), 32'(bubble_cnt_o), (k + 1 > 15) ? 15 : k + 1);
      step();
    end
    chk("sat ex_rd", 32'(ex_rd_o), 0);
    flush = 1'b0;
    drive(nop, 0, 0, 0);
    step();
    chk("sat final cnt", 32'(bubble_cnt_o), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
